// File: rtl/syscall_unit.sv
// syscall_unit: console/exit services for a MIPS-style core (print_char, print_string, exit, optional print_int).
// Latency: the issuing cycle is already stalled; print_char needs >=1 more cycle, print_string 2 cycles per word read + 1 per byte.
// Backpressure: char_valid/char_out are held until a rising edge with char_ready=1; the pipeline stays stalled meanwhile.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   syscall             - SYSCALL decoded this cycle
//   sys_call_reg        - v0, service code
//   std_out_address     - a0, service argument
//   mem_addr/mem_rd_en  - word-aligned data-memory read, data returns next cycle on mem_rd_data
//   char_out/char_valid - console character, accepted when char_ready is high on a rising edge
//   stall               - freezes the CPU pipeline while a service runs
//   halt                - sticky program-exit flag, cleared only by reset
//
// Build option: define SYSCALL_PRINT_INT_EN to include the v0=1 signed-decimal print service.
module syscall_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] sys_call_reg,
  input  logic [31:0] std_out_address,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        stall,
  output logic        halt
);

  typedef enum logic [2:0] {
    IDLE, STR_REQ, STR_WAIT, STR_EMIT, INT_CONV, INT_EMIT, CHAR_EMIT, HALTED
  } state_t;

  state_t      r_state, w_next;
  // r_ptr holds a0: the character for print_char, the byte pointer for print_string.
  logic [31:0] r_ptr,  w_ptr_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [11:0] r_cnt,  w_cnt_nxt;   // characters emitted by the current string
  logic [7:0]  w_byte;

`ifdef SYSCALL_PRINT_INT_EN
  logic [31:0] r_mag,     w_mag_nxt;     // remaining magnitude
  logic [3:0]  r_idx,     w_idx_nxt;     // 0 selects 10^9, 9 selects 10^0
  logic [3:0]  r_digit,   w_digit_nxt;
  logic        r_started, w_started_nxt; // a non-zero digit has been printed
  logic        r_last,    w_last_nxt;    // the pending character is the units digit
  logic [7:0]  r_char,    w_char_nxt;
  logic [31:0] w_pow;

  function automatic logic [31:0] pow10(input logic [3:0] idx);
    case (idx)
      4'd0:    pow10 = 32'd1000000000;
      4'd1:    pow10 = 32'd100000000;
      4'd2:    pow10 = 32'd10000000;
      4'd3:    pow10 = 32'd1000000;
      4'd4:    pow10 = 32'd100000;
      4'd5:    pow10 = 32'd10000;
      4'd6:    pow10 = 32'd1000;
      4'd7:    pow10 = 32'd100;
      4'd8:    pow10 = 32'd10;
      default: pow10 = 32'd1;
    endcase
  endfunction

  assign w_pow = pow10(r_idx);
`endif

  // Little-endian byte select within the fetched word.
  always_comb begin
    case (r_ptr[1:0])
      2'd0:    w_byte = r_word[7:0];
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_word    <= '0;
      r_cnt     <= '0;
`ifdef SYSCALL_PRINT_INT_EN
      r_mag     <= '0;
      r_idx     <= '0;
      r_digit   <= '0;
      r_started <= 1'b0;
      r_last    <= 1'b0;
      r_char    <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_ptr     <= w_ptr_nxt;
      r_word    <= w_word_nxt;
      r_cnt     <= w_cnt_nxt;
`ifdef SYSCALL_PRINT_INT_EN
      r_mag     <= w_mag_nxt;
      r_idx     <= w_idx_nxt;
      r_digit   <= w_digit_nxt;
      r_started <= w_started_nxt;
      r_last    <= w_last_nxt;
      r_char    <= w_char_nxt;
`endif
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ptr_nxt  = r_ptr;
    w_word_nxt = r_word;
    w_cnt_nxt  = r_cnt;
`ifdef SYSCALL_PRINT_INT_EN
    w_mag_nxt     = r_mag;
    w_idx_nxt     = r_idx;
    w_digit_nxt   = r_digit;
    w_started_nxt = r_started;
    w_last_nxt    = r_last;
    w_char_nxt    = r_char;
`endif
    mem_rd_en  = 1'b0;
    mem_addr   = {r_ptr[31:2], 2'b00};  // ptr is frozen from STR_REQ through STR_WAIT
    char_valid = 1'b0;
    char_out   = 8'h00;
    halt       = (r_state == HALTED);
    // HALTED releases the pipeline so the core can sit at its exit point.
    stall      = (r_state != IDLE) && (r_state != HALTED);

    case (r_state)
      IDLE: begin
        stall = syscall;
        if (syscall) begin
          w_ptr_nxt = std_out_address;
          w_cnt_nxt = '0;
          case (sys_call_reg)
            32'd11: w_next = CHAR_EMIT;
            32'd4:  w_next = STR_REQ;
            32'd10: w_next = HALTED;
`ifdef SYSCALL_PRINT_INT_EN
            32'd1: begin
              w_mag_nxt     = std_out_address[31] ? (~std_out_address + 32'd1) : std_out_address;
              w_idx_nxt     = '0;
              w_digit_nxt   = '0;
              w_started_nxt = 1'b0;
              w_last_nxt    = 1'b0;
              if (std_out_address[31]) begin
                w_char_nxt = 8'h2D;  // '-' goes out before any digit is computed
                w_next     = INT_EMIT;
              end else begin
                w_next     = INT_CONV;
              end
            end
`endif
            default: w_next = IDLE;  // unsupported code: the issuing stall is the whole service
          endcase
        end
      end

      CHAR_EMIT: begin
        char_valid = 1'b1;
        char_out   = r_ptr[7:0];
        if (char_ready) w_next = IDLE;
      end

      STR_REQ: begin
        mem_rd_en = 1'b1;
        w_next    = STR_WAIT;
      end

      STR_WAIT: begin
        w_word_nxt = mem_rd_data;
        w_next     = STR_EMIT;
      end

      STR_EMIT: begin
        if (w_byte == 8'h00) begin
          w_next = IDLE;
        end else begin
          char_valid = 1'b1;
          char_out   = w_byte;
          if (char_ready) begin
            w_ptr_nxt = r_ptr + 32'd1;
            w_cnt_nxt = r_cnt + 12'd1;
            if (r_cnt == 12'hFFF)        w_next = IDLE;     // 4096th character ends the string
            else if (r_ptr[1:0] == 2'b11) w_next = STR_REQ; // next byte lives in the next word
          end
        end
      end

`ifdef SYSCALL_PRINT_INT_EN
      INT_CONV: begin
        if (r_mag >= w_pow) begin
          w_mag_nxt   = r_mag - w_pow;
          w_digit_nxt = r_digit + 4'd1;
        end else if ((r_digit != 4'd0) || r_started || (r_idx == 4'd9)) begin
          w_char_nxt    = 8'h30 + {4'h0, r_digit};
          w_started_nxt = 1'b1;
          w_last_nxt    = (r_idx == 4'd9);
          w_idx_nxt     = r_idx + 4'd1;
          w_digit_nxt   = '0;
          w_next        = INT_EMIT;
        end else begin
          w_idx_nxt = r_idx + 4'd1;  // leading zero suppressed
        end
      end

      INT_EMIT: begin
        char_valid = 1'b1;
        char_out   = r_char;
        if (char_ready) w_next = r_last ? IDLE : INT_CONV;
      end
`endif

      HALTED: w_next = HALTED;

      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: table of service calls plus hand-written
// sequences for backpressure, the 4096-character limit, reset mid-service,
// reset/syscall priority and exit. Characters are checked through a scoreboard queue.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        reset, syscall, char_ready;
  logic [31:0] sys_call_reg, std_out_address, mem_rd_data;
  logic [31:0] mem_addr;
  logic        mem_rd_en, char_valid, stall, halt;
  logic [7:0]  char_out;

  logic [31:0] mem [0:4095];
  byte         exp_q[$];
  byte         mon_e;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    string       exp;
    int          nstall;  // total stalled cycles including the issuing one; -1 = not checked
    string       name;
  } vec_t;
  vec_t vecs[$];

  syscall_unit dut (
    .clk(clk), .reset(reset), .syscall(syscall), .sys_call_reg(sys_call_reg),
    .std_out_address(std_out_address), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .stall(stall), .halt(halt)
  );

  always #5 clk = ~clk;

  // One-cycle-latency data memory.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[13:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Console side: a transfer happens on the coming rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_char: got 0x%0h, none expected", char_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("char", {24'h0, char_out}, {24'h0, mon_e});
      end
    end
    if (mem_rd_en) chk("mem_addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
  end

  task automatic add_vec(input logic [31:0] v0, input logic [31:0] a0, input string exp,
                         input int nstall, input string name);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.exp = exp; v.nstall = nstall; v.name = name;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the service has finished.
  task automatic do_call(input logic [31:0] v0, input logic [31:0] a0, input string exp,
                         input int nstall, input string name);
    int n;
    for (int i = 0; i < exp.len(); i++) exp_q.push_back(exp[i]);
    syscall = 1'b1; sys_call_reg = v0; std_out_address = a0;
    @(negedge clk);
    chk({name, "_issue_stall"}, {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    syscall = 1'b0;
    n = 1;
    while (n < 20000) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk({name, "_finished"}, {31'h0, stall}, 32'd0);
    chk({name, "_chars_left"}, exp_q.size(), 32'd0);
    if (nstall > 0) chk({name, "_stall_cycles"}, n, nstall);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h2E2E2E2E;  // '.' everywhere, no NUL
    mem[12'h040] = 32'h00434241;  // 0x100: "ABC\0"
    mem[12'h041] = 32'h67666564;  // 0x104: "defg"
    mem[12'h042] = 32'h00006968;  // 0x108: "hi\0\0"

    add_vec(32'd11, 32'h41,  "A",      2,  "char_A");
    add_vec(32'd4,  32'h102, "C",      5,  "str_off2");
    add_vec(32'd4,  32'h100, "ABC",    7,  "str_ABC");
    add_vec(32'd4,  32'h104, "defghi", 12, "str_cross");
    add_vec(32'd4,  32'h10A, "",       4,  "str_empty");
    add_vec(32'd7,  32'h0,   "",       1,  "unsupported7");
    add_vec(32'd11, 32'h1FF, "\377",   2,  "char_lowbyte");
`ifdef SYSCALL_PRINT_INT_EN
    add_vec(32'd1,  32'h0,        "0",           -1, "int_zero");
    add_vec(32'd1,  32'hFFFFFF85, "-123",        -1, "int_m123");
    add_vec(32'd1,  32'h80000000, "-2147483648", -1, "int_min");
    add_vec(32'd1,  32'd1000000000, "1000000000", -1, "int_1e9");
    add_vec(32'd1,  32'h7FFFFFFF, "2147483647",  -1, "int_max");
    add_vec(32'd1,  32'hFFFFFFFF, "-1",          -1, "int_m1");
`else
    add_vec(32'd1,  32'd5,    "",            1,  "int_disabled");
`endif

    reset = 1'b1; syscall = 1'b0; sys_call_reg = '0; std_out_address = '0; char_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_halt",      {31'h0, halt},       32'd0);
    chk("rst_valid",     {31'h0, char_valid}, 32'd0);
    chk("rst_char_out",  {24'h0, char_out},   32'd0);
    chk("rst_rd_en",     {31'h0, mem_rd_en},  32'd0);
    chk("rst_mem_addr",  mem_addr,            32'd0);
    chk("rst_stall",     {31'h0, stall},      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) do_call(vecs[i].v0, vecs[i].a0, vecs[i].exp, vecs[i].nstall, vecs[i].name);

    // print_char held off by the console for several cycles.
    char_ready = 1'b0;
    exp_q.push_back(8'h5A);
    syscall = 1'b1; sys_call_reg = 32'd11; std_out_address = 32'h5A;
    @(posedge clk); #1;
    syscall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, char_valid}, 32'd1);
      chk("bp_data",  {24'h0, char_out},   32'h5A);
      chk("bp_stall", {31'h0, stall},      32'd1);
    end
    @(posedge clk); #1;
    char_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_sent", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("bp_done_stall", {31'h0, stall},      32'd0);
    chk("bp_done_valid", {31'h0, char_valid}, 32'd0);
    @(posedge clk); #1;

    // String without NUL stops after 4096 characters.
    for (int k = 0; k < 4096; k++) exp_q.push_back(8'h2E);
    do_call(32'd4, 32'h1000, "", -1, "str_4096");

    // Reset in the middle of a string with a character pending.
    char_ready = 1'b0;
    syscall = 1'b1; sys_call_reg = 32'd4; std_out_address = 32'h104;
    @(posedge clk); #1;
    syscall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_valid_before", {31'h0, char_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid",    {31'h0, char_valid}, 32'd0);
    chk("mid_rst_stall",    {31'h0, stall},      32'd0);
    chk("mid_rst_rd_en",    {31'h0, mem_rd_en},  32'd0);
    chk("mid_rst_mem_addr", mem_addr,            32'd0);
    chk("mid_rst_char_out", {24'h0, char_out},   32'd0);
    @(posedge clk); #1;
    reset = 1'b0; char_ready = 1'b1;
    @(negedge clk);
    chk("mid_after_valid", {31'h0, char_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset wins over a syscall on the same edge.
    syscall = 1'b1; sys_call_reg = 32'd11; std_out_address = 32'h33; reset = 1'b1;
    @(negedge clk);
    chk("pri_stall_comb", {31'h0, stall}, 32'd1);
    @(posedge clk); #1;
    syscall = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("pri_valid", {31'h0, char_valid}, 32'd0);
    chk("pri_stall", {31'h0, stall},      32'd0);
    @(posedge clk); #1;

    // Exit: halt is sticky, further syscalls are ignored, reset clears it.
    do_call(32'd10, 32'h0, "", 1, "exit");
    @(negedge clk);
    chk("exit_halt",  {31'h0, halt},  32'd1);
    chk("exit_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    syscall = 1'b1; sys_call_reg = 32'd11; std_out_address = 32'h44;
    @(negedge clk);
    chk("halted_ignore_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    syscall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("halted_valid", {31'h0, char_valid}, 32'd0);
      chk("halted_halt",  {31'h0, halt},       32'd1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_clears_halt", {31'h0, halt}, 32'd0);
    @(posedge clk); #1;
    do_call(32'd11, 32'h21, "!", 2, "char_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port syscall, input, 1 bit: decode flags a SYSCALL instruction this cycle.
REQ-004 SHALL have port sys_call_reg, input, 32 bits: current value of register $2 (v0), the service code.
REQ-005 SHALL have port std_out_address, input, 32 bits: current value of register $4 (a0), the service argument.
REQ-006 SHALL have port mem_addr, output, 32 bits: word-aligned data-memory read address.
REQ-007 SHALL have port mem_rd_en, output, 1 bit: read request; data is returned one cycle later.
REQ-008 SHALL have port mem_rd_data, input, 32 bits: read data, valid on the cycle after mem_rd_en.
REQ-009 SHALL have port char_out, output, 8 bits: console character.
REQ-010 SHALL have port char_valid, output, 1 bit: char_out holds a valid character.
REQ-011 SHALL have port char_ready, input, 1 bit: console accepts char_out this cycle.
REQ-012 SHALL have port stall, output, 1 bit: freezes the CPU pipeline while a service runs.
REQ-013 SHALL have port halt, output, 1 bit: sticky program-exit flag.

Function
REQ-014 SHALL, in IDLE with syscall=1 and halt=0, latch v0 and a0 on that edge and dispatch on v0.
REQ-015 SHALL drive stall = syscall OR (state != IDLE) combinationally, so the issuing cycle is already stalled.
REQ-016 SHALL implement these states: IDLE, STR_REQ, STR_WAIT, STR_EMIT, INT_CONV, INT_EMIT, CHAR_EMIT, HALTED.
REQ-017 SHALL handle v0=11 (print_char): CHAR_EMIT presents a0[7:0], then returns to IDLE on handshake.
REQ-018 SHALL handle v0=4 (print_string): STR_REQ issues mem_rd_en with mem_addr = {ptr[31:2],2'b00}; STR_WAIT captures the word; STR_EMIT selects the byte by ptr[1:0], little-endian (offset 0 = bits 7:0).
REQ-019 SHALL, for a string byte, return to IDLE without output if the byte is 0x00; otherwise emit the byte, increment ptr on handshake, and re-read memory only when ptr crosses a word boundary.
REQ-020 SHALL end a string after 4096 emitted characters even if no NUL has been found, returning to IDLE.
REQ-021 SHALL handle v0=10 (exit): set halt=1, enter HALTED, and remain there until reset; stall=0 in HALTED and syscall is ignored.
REQ-022 SHALL complete any other v0 value with no output, returning to IDLE on the next edge (one stalled cycle).
REQ-023 SHALL obey the handshake: char_valid held and char_out stable until a rising edge with char_ready=1; transfer occurs only on that edge.
REQ-024 SHALL ignore syscall when the state is not IDLE.
REQ-025 SHALL keep mem_rd_en low except in STR_REQ, and keep mem_addr stable from STR_REQ through STR_WAIT.

Reset
REQ-026 SHALL, on a rising edge with reset=1, set state to IDLE, halt=0, char_valid=0, char_out=0, mem_rd_en=0, mem_addr=0, with stall=0 unless syscall=1.
REQ-027 SHALL, on reset mid-service, abandon the service; any character not yet handshaken is dropped.
REQ-028 SHALL give reset priority over syscall when both are high on the same edge.

Configuration
REQ-029 SHALL compile the v0=1 (print_int) service in when macro SYSCALL_PRINT_INT_EN is defined.
REQ-030 SHALL, with the macro defined, print signed decimal a0: '-' if negative, the magnitude as 32-bit unsigned, and digits from repeated subtraction of 10^9 down to 10^0 in INT_CONV (at most one subtraction per cycle), with leading zeros suppressed and value 0 printing "0".
REQ-031 SHALL, without the macro, treat v0=1 as unsupported per REQ-022, with no conversion logic synthesized.

Verification
REQ-032 SHALL cover: v0=11, a0=0x41, char_ready=1 -> one transfer of 0x41, then stall low and state IDLE.
REQ-033 SHALL cover: v0=4, a0=0x102, memory word 0x100=0x00434241 -> "C" only, then NUL ends the service; a0=0x100 -> "ABC".
REQ-034 SHALL cover: print_char with char_ready held low for 5 cycles -> char_out stable and char_valid high throughout; transfer on the first ready edge.
REQ-035 SHALL cover, with SYSCALL_PRINT_INT_EN: a0=0 -> "0"; a0=0xFFFFFF85 -> "-123"; a0=0x80000000 -> "-2147483648".
REQ-036 SHALL cover: v0=10 -> halt=1 and stall=0; a later syscall has no effect; reset clears halt.
REQ-037 SHALL cover: reset asserted mid-string -> next edge char_valid=0 and state IDLE; v0=7 -> exactly one stalled cycle with no output.
